rr_grant_scheduler_4: RTL and testbench
=======================================

// Module: rr_grant_scheduler_4
// PURPOSE
// - Round-robin scheduler sharing one 2-to-4 decoded resource among 4 requesters.
// - Picks a winner, holds its grant while its request stays high, then rotates fairly.
// - The 2-bit sel output drives the decoder input. grant[3:0] is the registered one-hot decode of sel.
// - Sits between the requesting units and the shared decoder/enable fabric.
// PARAMETERS
// - MAX_HOLD  8  Max consecutive grant cycles before a forced rotate (only with RR_TIMEOUT_EN).
// - CNT_W     4  Hold-counter width. Must satisfy 2**CNT_W > MAX_HOLD.
// PORTS
// - clk    input   1  Rising-edge clock.
// - reset  input   1  Asynchronous, active-high reset.
// - req    input   4  Request per requester. Level-sensitive; bit i = requester i.
// - sel    output  2  Index of the current owner; feeds the 2-to-4 decoder in.
// - grant  output  4  One-hot grant. Equals 1<<sel when busy, else 4'b0000.
// - busy   output  1  High while any grant is active.
// BEHAVIOUR
// - All outputs are registered.
// - Reset (asynchronous): sel=2'b00, grant=4'b0000, busy=0, state=IDLE, hold_cnt=0.
//   - Reset also sets last=2'b11, so requester 0 has first priority.
// - Priority: search order is last+1, last+2, last+3, last (mod 4). The first set req bit wins.
// - State IDLE (busy=0):
//   - If req==0, stay in IDLE.
//   - If req!=0, go to GRANT. sel=winner, grant=1<<winner, busy=1 on the next edge (latency 1).
// - State GRANT: on each edge, with o = the current sel:
//   - req[o]=1 and no timeout: hold. Outputs unchanged; hold_cnt increments.
//   - req[o]=0 and other req bits set: go directly to the next winner. No idle bubble.
//     - last=o, hold_cnt=0.
//   - req[o]=0 and req==0: go to IDLE. grant=0, busy=0. sel keeps its old value; last=o.
// - Simultaneous requests: the winner is resolved only by the rotating order above, never by index.
// - A requester that drops and re-raises req in the same ownership window gets no re-grant.
//   - It waits its turn, unless it is the only one requesting.
// - Wrap-around: the last pointer is 2-bit modular (3+1 -> 0).
// - grant is always zero or one-hot; never multi-hot.
// - Reset asserted mid-grant clears outputs immediately, without waiting for a clock edge.
// - After reset releases, arbitration restarts from requester 0 priority.
// - Inputs are treated as synchronous to clk; no internal synchronizers.
// CONFIGURATION
// - RR_TIMEOUT_EN defined:
//   - hold_cnt counts grant cycles.
//   - When hold_cnt==MAX_HOLD-1 and any other req bit is set, the next edge forces a rotate to the next winner.
//     - The owner's req is ignored for this decision. last=o, hold_cnt=0.
//   - If no other requester is pending, hold_cnt saturates at MAX_HOLD-1 and the owner keeps the grant.
// - RR_TIMEOUT_EN undefined:
//   - No hold counter logic. A grant is held until the owner drops req.
// TESTING
// 1. req=4'b0000 for 10 cycles -> grant=0, busy=0, sel=0. Assert reset -> outputs 0 asynchronously.
// 2. From reset, req=4'b1111 -> next edge: sel=0, grant=4'b0001.
//    Drop each owner's req in turn -> grants 0001, 0010, 0100, 1000 with no idle cycle between.
// 3. Owner=3 drops while req=4'b0011 -> next grant 4'b0001 (wrap-around).
//    Then all req=0 -> grant=0, busy=0 one edge later.
// 4. RR_TIMEOUT_EN, MAX_HOLD=8: req=4'b0101 held static -> grant 0001 for exactly 8 cycles, then 0100 for 8, alternating.
//    Without the macro -> 0001 held indefinitely.
// 5. RR_TIMEOUT_EN: only req[2] high for 20 cycles -> grant=4'b0100 continuously.
//    hold_cnt saturates; no glitch to 0.
// 6. Assert reset mid-grant (grant=4'b0100) between edges -> grant=0, busy=0 immediately.
//    Release with req=4'b1100 -> first grant 4'b0100 (priority restarts at requester 0).
// - Every cycle, check: grant==(busy ? 1<<sel : 0) and $countones(grant)<=1.

Source files
------------

// File: rtl/rr_grant_scheduler_4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_scheduler_4
//  Purpose  : Round-robin scheduler that shares one 2-to-4 decoded resource
//             among four requesters. A winner keeps the grant while its
//             request stays high. When it releases, ownership rotates fairly
//             to the next requester with no idle cycle between owners.
//  Options  : RR_TIMEOUT_EN - when defined, an owner that has held the grant
//             for MAX_HOLD cycles is forced to rotate if another requester
//             is pending.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy
);

  // --------------------------------------------------------------------------
  // Configuration sanity: the hold counter must be able to reach MAX_HOLD-1.
  // --------------------------------------------------------------------------
  if ((MAX_HOLD < 1) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_cfg_invalid
    $error("rr_grant_scheduler_4: CNT_W too narrow for MAX_HOLD");
  end

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;
  logic [3:0] r_grant;
  logic [3:0] w_grant_nxt;
  logic       r_busy;
  logic       w_busy_nxt;

  // Request vector with the current owner removed; used for rotation.
  logic [3:0] w_others;
  // Owner still requesting.
  logic       w_owner_req;
  // Forced rotation due to hold timeout (always low without the option).
  logic       w_force_rotate;

  // {found, index} results of the two priority searches.
  logic [2:0] w_idle_pick;
  logic [2:0] w_rot_pick;

  // --------------------------------------------------------------------------
  // Rotating priority search: order is base+1, base+2, base+3, base.
  // Iterating from lowest priority to highest lets the highest-priority hit
  // overwrite any earlier one.
  // --------------------------------------------------------------------------
  function automatic logic [2:0] f_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Combinational helpers for the next-state logic.
  assign w_others    = req & ~(4'b0001 << r_sel);
  assign w_owner_req = req[r_sel];
  assign w_idle_pick = f_pick(req, r_last);
  // The owner is excluded; the search starts just after it, so after the
  // owner releases, the next requester in rotation order wins.
  assign w_rot_pick  = f_pick(w_others, r_sel);

`ifdef RR_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Hold counter: counts cycles the current owner has held the grant.
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic             w_hold_expired;

  assign w_hold_expired = (r_hold_cnt == C_HOLD_LAST);
  // The owner's own request is ignored once its hold window expires and
  // somebody else is waiting.
  assign w_force_rotate = (r_state == ST_GRANT) && w_hold_expired && (w_others != 4'b0000);

  // Hold counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end
`else
  // Without the timeout option a grant is held until the owner releases.
  assign w_force_rotate = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State and output registers; reset clears the outputs immediately and
  // points last at requester 3 so requester 0 gets first priority.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'b00;
      r_last  <= 2'b11;
      r_grant <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
`ifdef RR_TIMEOUT_EN
    w_hold_cnt_nxt = r_hold_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_idle_pick[2]) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_idle_pick[1:0];
          w_grant_nxt = 4'b0001 << w_idle_pick[1:0];
          w_busy_nxt  = 1'b1;
`ifdef RR_TIMEOUT_EN
          w_hold_cnt_nxt = '0;
`endif
        end
      end

      ST_GRANT: begin
        if (w_owner_req && !w_force_rotate) begin
          // Owner keeps the grant; outputs unchanged.
`ifdef RR_TIMEOUT_EN
          if (r_hold_cnt != C_HOLD_LAST) begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
          end
`endif
        end else if (w_rot_pick[2]) begin
          // Hand over directly to the next winner, no idle bubble.
          w_last_nxt  = r_sel;
          w_sel_nxt   = w_rot_pick[1:0];
          w_grant_nxt = 4'b0001 << w_rot_pick[1:0];
          w_busy_nxt  = 1'b1;
`ifdef RR_TIMEOUT_EN
          w_hold_cnt_nxt = '0;
`endif
        end else begin
          // Nobody requesting: release; sel keeps the previous owner.
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_sel;
          w_grant_nxt = 4'b0000;
          w_busy_nxt  = 1'b0;
`ifdef RR_TIMEOUT_EN
          w_hold_cnt_nxt = '0;
`endif
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign sel   = r_sel;
  assign grant = r_grant;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_scheduler_4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_grant_scheduler_4
//  Purpose  : Directed self-checking bench for rr_grant_scheduler_4.
//             Expectations follow RR_TIMEOUT_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_scheduler_4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_grant_scheduler_4 #(
    .MAX_HOLD (8),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .sel   (sel),
    .grant (grant),
    .busy  (busy)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all three outputs against hand-computed values.
  task automatic expect_out(input string tag, input logic [1:0] es,
                            input logic [3:0] eg, input logic eb);
    n_checks++;
    assert (sel === es) else begin
      n_fail++;
      $error("FAIL %s sel: got %0d expected %0d", tag, sel, es);
    end
    n_checks++;
    assert (grant === eg) else begin
      n_fail++;
      $error("FAIL %s grant: got %b expected %b", tag, grant, eg);
    end
    n_checks++;
    assert (busy === eb) else begin
      n_fail++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, eb);
    end
  endtask

  // Every-cycle invariants: grant tracks sel/busy and is never multi-hot.
  always @(negedge clk) begin
    n_checks++;
    assert (grant === (busy ? (4'b0001 << sel) : 4'b0000)) else begin
      n_fail++;
      $error("FAIL inv_decode: grant=%b sel=%0d busy=%b", grant, sel, busy);
    end
    n_checks++;
    assert ($countones(grant) <= 1) else begin
      n_fail++;
      $error("FAIL inv_onehot: grant=%b", grant);
    end
  end

  initial begin
    logic [1:0] exp_sel;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    expect_out("reset_state", 2'd0, 4'b0000, 1'b0);
    reset = 1'b0;

    // No requests: stays idle.
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("idle_noreq", 2'd0, 4'b0000, 1'b0);
    end
    #2 reset = 1'b1;
    #1 expect_out("reset_idle_async", 2'd0, 4'b0000, 1'b0);
    tick();
    #2 reset = 1'b0;

    // All request: requester 0 first, then rotate as each owner drops.
    req = 4'b1111; tick(); expect_out("all_req_first", 2'd0, 4'b0001, 1'b1);
    req = 4'b1110; tick(); expect_out("rotate_to_1",   2'd1, 4'b0010, 1'b1);
    req = 4'b1100; tick(); expect_out("rotate_to_2",   2'd2, 4'b0100, 1'b1);
    req = 4'b1000; tick(); expect_out("rotate_to_3",   2'd3, 4'b1000, 1'b1);

    // Wrap-around from owner 3 to requester 0, then release.
    req = 4'b0011; tick(); expect_out("wrap_3_to_0",   2'd0, 4'b0001, 1'b1);
    req = 4'b0000; tick(); expect_out("release_idle0", 2'd0, 4'b0000, 1'b0);
    req = 4'b0010; tick(); expect_out("idle_to_1",     2'd1, 4'b0010, 1'b1);
    req = 4'b0000; tick(); expect_out("release_keep1", 2'd1, 4'b0000, 1'b0);

    // From idle with last=1: requester 2 beats lower-index requester 1.
    req = 4'b0110; tick(); expect_out("rot_not_index", 2'd2, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("hold_owner2", 2'd2, 4'b0100, 1'b1);
    end
    req = 4'b0010; tick(); expect_out("drop2_to_1",   2'd1, 4'b0010, 1'b1);
    req = 4'b0011; tick(); expect_out("hold_owner1",  2'd1, 4'b0010, 1'b1);

    // Owner 1 drops with 0 and 2 pending: 2 is next in rotation.
    req = 4'b0101; tick(); expect_out("static_0101_j0", 2'd2, 4'b0100, 1'b1);
    for (int j = 1; j < 32; j++) begin
      tick();
`ifdef RR_TIMEOUT_EN
      exp_sel = (((j / 8) % 2) == 0) ? 2'd2 : 2'd0;
`else
      exp_sel = 2'd2;
`endif
      expect_out("static_0101", exp_sel, 4'b0001 << exp_sel, 1'b1);
    end

    // Lone requester 2 keeps the grant continuously.
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out("lone_req2", 2'd2, 4'b0100, 1'b1);
    end

    // Reset between edges while requester 2 owns the grant.
    #2 reset = 1'b1;
    #1 expect_out("reset_mid_grant", 2'd0, 4'b0000, 1'b0);
    req = 4'b1100;
    tick(); expect_out("held_in_reset", 2'd0, 4'b0000, 1'b0);
    #2 reset = 1'b0;
    tick(); expect_out("post_reset_pri", 2'd2, 4'b0100, 1'b1);
    req = 4'b1000; tick(); expect_out("post_reset_to3", 2'd3, 4'b1000, 1'b1);
    req = 4'b0001; tick(); expect_out("post_reset_wrap", 2'd0, 4'b0001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
